adc128s_model: RTL and testbench
================================

Name: adc128s_model

Overview:
- Behavioural, clock-synchronous model of an 8-channel, 12-bit SPI A2D converter of the ADC128S type.
- The audio equalizer reads its slide-pot settings from this block: four band gains plus volume.
- The block answers 16-bit SPI frames with a fixed per-channel 12-bit value.
- The channel used in each frame is the one addressed by the previous frame, matching the real part's pipelined addressing.

Parameters:
- VAL_CH0, 12'h800, result returned for channel 0 (LP band gain, unity).
- VAL_CH1, 12'h000, result for channel 1 (band B1 gain).
- VAL_CH2, 12'h000, result for channel 2 (band B2 gain).
- VAL_CH3, 12'hFFF, result for channel 3 (volume, max).
- VAL_CH4, 12'h000, result for channel 4 (band HP gain).
- VAL_CH5..VAL_CH7, 12'h000, results for unused channels.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  SPI slave select, active low; one frame per low period.
- SCLK  in  1  SPI clock from the master, idle high; much slower than clk.
- MOSI  in  1  serial command from the master.
- MISO  out  1  serial result to the master.

Behaviour:
- Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high.
- Edge detection:
  - SCLK and SS_n are registered once per clk.
  - A fall or rise is detected when the registered value differs from the current input.
  - Edges take effect in the clk cycle after the input changes.
- Reset clears all state:
  - ch_sel=0, shift_tx=0, shift_rx=0, bit_cnt=0.
  - Registered SCLK=1, registered SS_n=1, so MISO=0.
- Frame start (SS_n falling edge):
  - shift_tx <= {4'b0000, VAL_CH[ch_sel]}.
  - bit_cnt <= 0; shift_rx <= 0.
- Output:
  - MISO = shift_tx[15] while SS_n is low.
  - MISO = 0 while SS_n is high; no tri-state.
- SCLK rising edge with SS_n low and bit_cnt<16:
  - shift_rx <= {shift_rx[14:0], MOSI}.
  - bit_cnt <= bit_cnt+1.
- SCLK falling edge with SS_n low:
  - shift_tx <= {shift_tx[14:0], 1'b0}.
  - The first falling edge after SS_n falls is ignored when bit_cnt==0, so bit 15 stays valid for the first rise.
- Result order: the master sees 4 leading zeros, then result bits 11..0 MSB first, sampled on SCLK rising edges 1..16.
- Frame end (SS_n rising edge):
  - If bit_cnt==16, ch_sel <= shift_rx[13:11] (address bits ADD2..ADD0 of the command).
  - Otherwise the frame is aborted and ch_sel is unchanged.
- Extra SCLK edges after 16 rises in one frame are ignored for bit_cnt and shift_rx; MISO shifts out zeros.
- SCLK edges while SS_n is high are ignored.
- If SS_n falls and SCLK changes in the same clk cycle, the frame start takes priority and the SCLK edge is dropped.
- Reset asserted mid-frame aborts the frame and applies the reset state above. Channel 0 is used next.
- Values are constant. The same channel read twice returns identical data.

Test Plan:
- Reset, then one frame with command 16'h1800 (addr 3) -> MISO returns VAL_CH0 = 0x800 (first frame uses ch 0).
- Second frame with command 16'h0000 -> MISO returns 0xFFF (channel 3 latched from the previous frame).
- Frames cycling addr 0..7 -> each response equals the value of the previously addressed channel. The first 4 bits of every response are 0.
- Abort: raise SS_n after 8 SCLK rises with addr 5 -> next frame still returns the value of the previously committed channel.
- Assert rst mid-frame, then run a full frame -> response is 0x800 (ch_sel reset to 0). MISO=0 while SS_n is high.
- Run 20 SCLK cycles in one frame -> only the first 16 bits are captured. The address decodes from bits [13:11] of the first 16 MOSI bits. MISO is 0 after bit 16.

Source files
------------

// File: rtl/adc128s_model.sv
// Behavioural clock-synchronous model of an ADC128S-style 8-channel 12-bit SPI A2D.
// Each 16-bit frame returns the fixed value of the channel addressed by the
// previous completed frame (pipelined addressing, as on the real part).
module adc128s_model #(
  parameter logic [11:0] VAL_CH0 = 12'h800,
  parameter logic [11:0] VAL_CH1 = 12'h000,
  parameter logic [11:0] VAL_CH2 = 12'h000,
  parameter logic [11:0] VAL_CH3 = 12'hFFF,
  parameter logic [11:0] VAL_CH4 = 12'h000,
  parameter logic [11:0] VAL_CH5 = 12'h000,
  parameter logic [11:0] VAL_CH6 = 12'h000,
  parameter logic [11:0] VAL_CH7 = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  logic        r_sclk;
  logic        r_ss_n;
  logic [2:0]  r_ch_sel;
  logic [15:0] r_shift_tx;
  logic [15:0] r_shift_rx;
  logic [4:0]  r_bit_cnt;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic [11:0] w_ch_val;

  // Edges are seen when the registered copy disagrees with the live input.
  assign w_sclk_rise = ~r_sclk &  SCLK;
  assign w_sclk_fall =  r_sclk & ~SCLK;
  assign w_ss_fall   =  r_ss_n & ~SS_n;
  assign w_ss_rise   = ~r_ss_n &  SS_n;

  // Fixed result for the currently selected channel.
  always_comb begin
    w_ch_val = VAL_CH0;
    case (r_ch_sel)
      3'd0: w_ch_val = VAL_CH0;
      3'd1: w_ch_val = VAL_CH1;
      3'd2: w_ch_val = VAL_CH2;
      3'd3: w_ch_val = VAL_CH3;
      3'd4: w_ch_val = VAL_CH4;
      3'd5: w_ch_val = VAL_CH5;
      3'd6: w_ch_val = VAL_CH6;
      3'd7: w_ch_val = VAL_CH7;
      default: w_ch_val = VAL_CH0;
    endcase
  end

  // MISO only drives data inside a frame; forced low otherwise (no tri-state).
  assign MISO = ~r_ss_n & r_shift_tx[15];

  // Input synchronisation registers for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk <= 1'b1;
      r_ss_n <= 1'b1;
    end else begin
      r_sclk <= SCLK;
      r_ss_n <= SS_n;
    end
  end

  // Frame control: load on SS_n fall, shift on SCLK edges, commit address on SS_n rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_sel   <= 3'd0;
      r_shift_tx <= 16'h0000;
      r_shift_rx <= 16'h0000;
      r_bit_cnt  <= 5'd0;
    end else if (w_ss_fall) begin
      // Frame start wins over any coincident SCLK edge.
      r_shift_tx <= {4'b0000, w_ch_val};
      r_shift_rx <= 16'h0000;
      r_bit_cnt  <= 5'd0;
    end else if (w_ss_rise) begin
      // Only a complete 16-bit frame updates the channel; short frames abort.
      if (r_bit_cnt == 5'd16)
        r_ch_sel <= r_shift_rx[13:11];
    end else if (!SS_n) begin
      if (w_sclk_rise && (r_bit_cnt < 5'd16)) begin
        r_shift_rx <= {r_shift_rx[14:0], MOSI};
        r_bit_cnt  <= r_bit_cnt + 5'd1;
      end
      // The leading fall before the first rise must not disturb bit 15.
      if (w_sclk_fall && (r_bit_cnt != 5'd0))
        r_shift_tx <= {r_shift_tx[14:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_adc128s_model.sv
// Directed bench for adc128s_model: SPI master tasks drive frames and compare
// each response against hand-derived channel values.
module tb_adc128s_model;

  logic clk;
  logic rst;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  int tests;
  int fails;

  adc128s_model dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-channel values (default parameters).
  function automatic logic [15:0] exp_val(input int ch);
    case (ch)
      0: exp_val = 16'h0800;
      3: exp_val = 16'h0FFF;
      default: exp_val = 16'h0000;
    endcase
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame of nbits SCLK cycles; MISO sampled just before each rise.
  // Bits beyond 16 drive MOSI=1 and count any MISO ones seen.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits,
                           output logic [15:0] resp, output int extra_ones);
    resp = 16'h0000;
    extra_ones = 0;
    @(negedge clk);
    SS_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      wait_clks(4);
      if (i < 16) resp[15-i] = MISO;
      else if (MISO) extra_ones++;
      SCLK = 1'b1;
      wait_clks(4);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wait_clks(3);
    tests++;
    if (MISO !== 1'b0) begin
      fails++;
      $display("FAIL reset_miso: got %b want 0", MISO);
    end
    rst = 1'b0;
    wait_clks(3);
    tests++;
    if (MISO !== 1'b0) begin
      fails++;
      $display("FAIL idle_miso: got %b want 0", MISO);
    end
  endtask

  task automatic test_first_frame();
    logic [15:0] r; int x;
    spi_frame(16'h1800, 16, r, x);
    tests++;
    if (r !== 16'h0800) begin
      fails++;
      $display("FAIL first_frame: got %h want 0800", r);
    end
  endtask

  task automatic test_latched();
    logic [15:0] r; int x;
    spi_frame(16'h0000, 16, r, x);
    tests++;
    if (r !== 16'h0FFF) begin
      fails++;
      $display("FAIL latched_ch3: got %h want 0fff", r);
    end
  endtask

  task automatic test_cycle();
    logic [15:0] r; int x; int prev;
    prev = 0;
    for (int a = 0; a < 8; a++) begin
      spi_frame(16'(a) << 11, 16, r, x);
      tests++;
      if (r !== exp_val(prev)) begin
        fails++;
        $display("FAIL cycle_addr%0d: got %h want %h", a, r, exp_val(prev));
      end
      tests++;
      if (r[15:12] !== 4'b0000) begin
        fails++;
        $display("FAIL cycle_lead%0d: got %b want 0000", a, r[15:12]);
      end
      prev = a;
    end
  endtask

  task automatic test_abort();
    logic [15:0] r; int x;
    spi_frame(16'h1800, 16, r, x);     // commit ch3; returns ch7 value
    tests++;
    if (r !== 16'h0000) begin
      fails++;
      $display("FAIL abort_setup: got %h want 0000", r);
    end
    spi_frame(16'h2800, 8, r, x);      // addr 5, aborted after 8 rises
    spi_frame(16'h0000, 16, r, x);
    tests++;
    if (r !== 16'h0FFF) begin
      fails++;
      $display("FAIL abort_keep: got %h want 0fff", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int x;
    spi_frame(16'h1800, 16, r, x);     // commit ch3
    tests++;
    if (r !== 16'h0800) begin
      fails++;
      $display("FAIL rstmid_setup: got %h want 0800", r);
    end
    @(negedge clk);
    SS_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; wait_clks(4);
      SCLK = 1'b1; wait_clks(4);
    end
    rst = 1'b1;
    wait_clks(2);
    tests++;
    if (MISO !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_miso: got %b want 0", MISO);
    end
    SS_n = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);
    tests++;
    if (MISO !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: got %b want 0", MISO);
    end
    spi_frame(16'h0000, 16, r, x);
    tests++;
    if (r !== 16'h0800) begin
      fails++;
      $display("FAIL rstmid_ch0: got %h want 0800", r);
    end
  endtask

  task automatic test_long_frame();
    logic [15:0] r; int x;
    spi_frame(16'h1800, 20, r, x);     // previous commit was ch0
    tests++;
    if (r !== 16'h0800) begin
      fails++;
      $display("FAIL long_resp: got %h want 0800", r);
    end
    tests++;
    if (x !== 0) begin
      fails++;
      $display("FAIL long_tail: got %0d ones want 0", x);
    end
    spi_frame(16'h0000, 16, r, x);
    tests++;
    if (r !== 16'h0FFF) begin
      fails++;
      $display("FAIL long_addr: got %h want 0fff", r);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    test_reset();
    test_first_frame();
    test_latched();
    test_cycle();
    test_abort();
    test_reset_mid();
    test_long_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
